// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage: default widths,
// reset PC, PC increment and the ROM request tracker entry.
package if_pkg;

   localparam int IF_ADDR_W = 32;
   localparam int IF_INST_W = 32;
   localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = '0;
   localparam int unsigned IF_PC_STEP = 4;

   // One in-flight ROM request. The epoch tag lets responses issued before a
   // redirect be recognised and dropped when they come back.
   typedef struct packed {
      logic                 valid;
      logic [IF_ADDR_W-1:0] pc;
      logic                 epoch;
   } trackEntry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-stage bus: the ROM request/response pair, ID-stage control (stall and
// redirect) and the instruction handed to ID. The master is the fetch stage.
interface if_prefetch_if import if_pkg::*; #(
   parameter int ADDR_W = IF_ADDR_W,
   parameter int INST_W = IF_INST_W
);
   logic              o_romEnable;
   logic [ADDR_W-1:0] o_romAddr;
   logic [INST_W-1:0] i_romInst;
   logic              i_stall;
   logic              i_takeBranch;
   logic [ADDR_W-1:0] i_jpc;
   logic              o_valid;
   logic [ADDR_W-1:0] o_pc;
   logic [INST_W-1:0] o_inst;

   modport master (
      output o_romEnable, o_romAddr, o_valid, o_pc, o_inst,
      input  i_romInst, i_stall, i_takeBranch, i_jpc
   );

   modport slave (
      input  o_romEnable, o_romAddr, o_valid, o_pc, o_inst,
      output i_romInst, i_stall, i_takeBranch, i_jpc
   );
endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with clear, occupancy count and combinational head data.
// DEPTH must be a power of two so the pointers wrap on their own.
module if_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic [WIDTH-1:0]           headData
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   cnt;
   logic             full;
   logic             doPush;
   logic             doPop;

   assign full     = (cnt == (PTR_W+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign doPop    = pop && !empty;
   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign doPush   = push && (!full || doPop);
   assign count    = cnt;
   assign headData = mem[rdPtr];

   // Pointer and occupancy tracking; clear empties the FIFO without touching storage.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         unique case ({doPush, doPop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (doPush && !rst && !clear) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with prefetch: PC generator, ROM request tracker and
// prefetch FIFO feeding the ID stage. Requests are only issued when the FIFO
// is guaranteed room for the response (count + in-flight < FIFO_DEPTH), so
// the FIFO never overflows. A redirect flushes the FIFO and bumps the epoch;
// responses tagged with the old epoch are dropped on arrival.
// Optional macro IF_PERF_CNT_EN adds saturating fetch and drop counters.
// ADDR_W must not exceed IF_ADDR_W (width of the tracker entry pc field).
module if_prefetch import if_pkg::*; #(
   parameter int                ADDR_W     = IF_ADDR_W,
   parameter int                INST_W     = IF_INST_W,
   parameter int                FIFO_DEPTH = 4,
   parameter int                ROM_LAT    = 1,
   parameter logic [ADDR_W-1:0] RESET_PC   = IF_RESET_PC,
   parameter int unsigned       PC_STEP    = IF_PC_STEP
) (
   input  logic                 clk,
   input  logic                 rst,
   if_prefetch_if.master        bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]          o_fetchCount,
   output logic [31:0]          o_dropCount
`endif
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_W-1:0] pc;
   logic              epoch;
   trackEntry_t       track [ROM_LAT];
   trackEntry_t       lastStage;
   logic [31:0]       inflight;
   logic              issue;
   logic              respFresh;
   logic              respStale;
   logic [ADDR_W-1:0] respPc;
   logic              fifoPush;
   logic              fifoPop;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoEmpty;
   logic [ADDR_W+INST_W-1:0] fifoHead;

   // Count requests still travelling through the ROM pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) inflight = inflight + 32'(track[i].valid);
   end

   assign issue = !rst && !bus.i_takeBranch &&
                  ((32'(fifoCount) + inflight) < 32'(FIFO_DEPTH));

   assign lastStage = track[ROM_LAT-1];
   assign respFresh = lastStage.valid && (lastStage.epoch == epoch);
   assign respStale = lastStage.valid && (lastStage.epoch != epoch);
   assign respPc    = ADDR_W'(lastStage.pc);

   assign fifoPush = respFresh && !bus.i_takeBranch;
   assign fifoPop  = !fifoEmpty && !bus.i_stall && !bus.i_takeBranch;

   assign bus.o_romEnable = issue;
   assign bus.o_romAddr   = pc;
   assign bus.o_valid     = !fifoEmpty;
   assign bus.o_pc        = fifoEmpty ? '0 : fifoHead[INST_W +: ADDR_W];
   assign bus.o_inst      = fifoEmpty ? '0 : fifoHead[INST_W-1:0];

   // PC generator and epoch: redirect reloads the PC and retires the old epoch.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         epoch <= 1'b0;
      end else if (bus.i_takeBranch) begin
         pc    <= bus.i_jpc;
         epoch <= ~epoch;
      end else if (issue) begin
         pc    <= pc + ADDR_W'(PC_STEP);
      end
   end

   // Request tracker: stage 0 captures this cycle's issue, older stages shift along.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROM_LAT; i++) track[i] <= '0;
      end else begin
         track[0].valid <= issue;
         track[0].pc    <= IF_ADDR_W'(pc);
         track[0].epoch <= epoch;
         for (int i = 1; i < ROM_LAT; i++) track[i] <= track[i-1];
      end
   end

   if_fifo #(
      .WIDTH (ADDR_W + INST_W),
      .DEPTH (FIFO_DEPTH)
   ) fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.i_takeBranch),
      .push     (fifoPush),
      .pushData ({respPc, bus.i_romInst}),
      .pop      (fifoPop),
      .count    (fifoCount),
      .empty    (fifoEmpty),
      .headData (fifoHead)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] dropInc;
   logic [32:0] dropSum;

   // A redirect discards every buffered entry plus any response landing that
   // same cycle (fresh or stale); otherwise only stale arrivals are dropped.
   always_comb begin
      if (bus.i_takeBranch) dropInc = 32'(fifoCount) + 32'(lastStage.valid);
      else                  dropInc = 32'(respStale);
      dropSum = {1'b0, o_dropCount} + {1'b0, dropInc};
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_fetchCount <= '0;
         o_dropCount  <= '0;
      end else begin
         if (issue && (o_fetchCount != '1)) o_fetchCount <= o_fetchCount + 1'b1;
         o_dropCount <= dropSum[32] ? '1 : dropSum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: two configurations (ROM_LAT=1 from PC 0, ROM_LAT=2
// from a PC just below the wrap point) run side by side under directed and
// randomized stall/redirect/reset stimulus, checked every cycle against a
// queue-based model of the fetch stream.
module tb_if_prefetch;
   import if_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfgGen
      localparam int LAT = (g == 0) ? 1 : 2;
      localparam logic [31:0] RPC = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
      localparam int DEPTH = 4;

      if_prefetch_if bus ();
`ifdef IF_PERF_CNT_EN
      logic [31:0] fetchCount;
      logic [31:0] dropCount;
`endif

      if_prefetch #(
         .ADDR_W     (32),
         .INST_W     (32),
         .FIFO_DEPTH (DEPTH),
         .ROM_LAT    (LAT),
         .RESET_PC   (RPC),
         .PC_STEP    (4)
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .bus          (bus)
`ifdef IF_PERF_CNT_EN
         ,
         .o_fetchCount (fetchCount),
         .o_dropCount  (dropCount)
`endif
      );

      // model state: expected fetch PC, buffered instruction PCs, outstanding
      // requests (arrival cycle, pc, redirect generation)
      logic [31:0] mPc;
      logic [31:0] mFifo [$];
      int          mDue [$];
      logic [31:0] mIpc [$];
      int          mIgen [$];
      int          mGen;
      int          mCyc;
      int          mFetch;
      int          mDrop;
      logic [31:0] pipeA [LAT];
      logic        pipeV [LAT];

      logic        stallNow;
      logic        brNow;
      logic [31:0] jpcNow;
      logic        expEn;
      logic        respHit;
      int          respGen;
      logic [31:0] respPc;
      string       pfx;

      initial begin
         mPc = RPC; mGen = 0; mCyc = 0; mFetch = 0; mDrop = 0;
         for (int i = 0; i < LAT; i++) begin pipeA[i] = '0; pipeV[i] = 1'b0; end
         bus.i_stall = 1'b0;
         bus.i_takeBranch = 1'b0;
         bus.i_jpc = '0;
         bus.i_romInst = '0;
         pfx = $sformatf("c%0d.", g);
      end

      always @(negedge clk) begin
         // stimulus for this cycle
         stallNow = 1'b0;
         brNow    = 1'b0;
         jpcNow   = $urandom & 32'hFFFF_FFFC;
         if (cyc >= 31 && cyc <= 44) stallNow = 1'b1;
         if (cyc >= 46 && cyc <= 53) stallNow = 1'b1;
         if (cyc == 25) begin brNow = 1'b1; jpcNow = 32'h0000_0400; end
         if (cyc == 53) begin brNow = 1'b1; jpcNow = 32'h0000_0800; end
         if (cyc >= 60 && cyc <= 400) begin
            stallNow = ($urandom_range(99) < 40);
            brNow    = ($urandom_range(99) < 8);
            if ($urandom_range(3) == 0) jpcNow = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
         end
         bus.i_stall      = stallNow;
         bus.i_takeBranch = brNow;
         bus.i_jpc        = jpcNow;
         bus.i_romInst    = pipeV[LAT-1] ? (pipeA[LAT-1] + 32'h100) : $urandom;
         #1;

         expEn = !rst && !brNow && ((mFifo.size() + mDue.size()) < DEPTH);
         checkVal({pfx, "valid"},   32'(bus.o_valid),     32'(mFifo.size() != 0));
         checkVal({pfx, "pc"},      bus.o_pc,             (mFifo.size() != 0) ? mFifo[0] : 32'h0);
         checkVal({pfx, "inst"},    bus.o_inst,           (mFifo.size() != 0) ? (mFifo[0] + 32'h100) : 32'h0);
         checkVal({pfx, "romEn"},   32'(bus.o_romEnable), 32'(expEn));
         checkVal({pfx, "romAddr"}, bus.o_romAddr,        mPc);
`ifdef IF_PERF_CNT_EN
         checkVal({pfx, "fetchCnt"}, fetchCount, 32'(mFetch));
         checkVal({pfx, "dropCnt"},  dropCount,  32'(mDrop));
`endif

         // ROM responder: returns addr+0x100 LAT cycles after each request
         for (int i = LAT - 1; i > 0; i--) begin
            pipeA[i] = pipeA[i-1];
            pipeV[i] = pipeV[i-1];
         end
         pipeA[0] = bus.o_romAddr;
         pipeV[0] = bus.o_romEnable;

         // advance the model by one clock edge
         if (rst) begin
            mFifo.delete(); mDue.delete(); mIpc.delete(); mIgen.delete();
            mPc = RPC; mGen = 0; mFetch = 0; mDrop = 0;
         end else begin
            respHit = 1'b0;
            respGen = 0;
            respPc  = '0;
            if (mDue.size() != 0 && mDue[0] == mCyc) begin
               respHit = 1'b1;
               void'(mDue.pop_front());
               respGen = mIgen.pop_front();
               respPc  = mIpc.pop_front();
            end
            if (brNow) begin
               mDrop += mFifo.size() + int'(respHit);
               mFifo.delete();
               mPc = jpcNow;
               mGen++;
            end else begin
               if (mFifo.size() != 0 && !stallNow) void'(mFifo.pop_front());
               if (respHit) begin
                  if (respGen == mGen) mFifo.push_back(respPc);
                  else mDrop++;
               end
               if (expEn) begin
                  mDue.push_back(mCyc + LAT);
                  mIpc.push_back(mPc);
                  mIgen.push_back(mGen);
                  mPc = mPc + 32'd4;
                  mFetch++;
               end
            end
         end
         mCyc++;
      end
   end

   initial begin
      rst = 1'b1;
      repeat (430) begin
         @(posedge clk);
         #2;
         cyc++;
         rst = (cyc < 3) || (cyc == 250) || (cyc == 251);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
